// File: rtl/mult_div_if.sv
// Command/result bundle between the execute stage and the multiply/divide unit.
// Pure wiring, no latency of its own.
// The busy vector is the only backpressure; the master must hold off long ops while it is non-zero.
interface mult_div_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [2:0]  busy;

  modport master (output start, op, a, b, input hi, lo, busy);
  modport slave  (input start, op, a, b, output hi, lo, busy);
endinterface

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Long ops write HI/LO MULT_CYCLES / DIV_CYCLES edges after acceptance; MTHI/MTLO take one edge.
// busy[0] (combinational) freezes decode on the accepting cycle; starts while busy are ignored.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave io
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MUL_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] res_hi, res_lo;
  logic [31:0] hi_q, lo_q;
  logic        div_zero;

  logic [63:0] prod;
  logic [31:0] quot, rem;
  logic        accept;

  // Product and quotient/remainder computed from the live operands, captured on acceptance
  always_comb begin
    logic [63:0] ext_a, ext_b;
    logic        sgn, neg_a, neg_b;
    logic [31:0] mag_a, mag_b, uq, ur;
    sgn   = (io.op == OP_DIV);
    ext_a = (io.op == OP_MULT) ? {{32{io.a[31]}}, io.a} : {32'd0, io.a};
    ext_b = (io.op == OP_MULT) ? {{32{io.b[31]}}, io.b} : {32'd0, io.b};
    prod  = ext_a * ext_b;
    // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of overflowing
    neg_a = sgn & io.a[31];
    neg_b = sgn & io.b[31];
    mag_a = neg_a ? (32'd0 - io.a) : io.a;
    mag_b = (io.b == 32'd0) ? 32'd1 : (neg_b ? (32'd0 - io.b) : io.b);
    uq    = mag_a / mag_b;
    ur    = mag_a % mag_b;
    quot  = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem   = neg_a ? (32'd0 - ur) : ur;
  end

  // Decode stall must rise in the same cycle a long op is accepted
  assign accept  = io.start && (state == S_IDLE) && !reset;
  assign io.busy = {state == S_DIV, state == S_MUL, accept && !io.op[2]};
  assign io.hi   = hi_q;
  assign io.lo   = lo_q;

  // Command acceptance, latency countdown and HI/LO commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      res_hi   <= 32'd0;
      res_lo   <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.start) begin
            case (io.op)
              OP_MULT, OP_MULTU: begin
                res_hi <= prod[63:32];
                res_lo <= prod[31:0];
                cnt    <= MUL_N;
                state  <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                res_hi   <= rem;
                res_lo   <= quot;
                div_zero <= (io.b == 32'd0);
                cnt      <= DIV_N;
                state    <= S_DIV;
              end
              OP_MTHI: hi_q <= io.a;
              OP_MTLO: lo_q <= io.a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (cnt == 4'd1) begin
            // Divide by zero burns the full latency but leaves HI/LO untouched
            if (!(state == S_DIV && div_zero)) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            cnt   <= 4'd0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a HI/LO scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// Expected HI/LO pairs are queued when a command is driven and popped when it retires.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] sb_q[$];

  mult_div_if bus();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_retire();
    logic [63:0] e;
    chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("hi_result", 64'(bus.hi), 64'(e[63:32]));
      chk("lo_result", 64'(bus.lo), 64'(e[31:0]));
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  // One long op; inj >= 0 injects an MTLO 0xDEAD start on that busy cycle
  task automatic long_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] eh, input logic [31:0] el, input int n, input int inj);
    int cyc;
    logic [2:0] bits;
    bits = (o < 3'd2) ? 3'b010 : 3'b100;
    bus.start = 1'b1; bus.op = o; bus.a = aa; bus.b = bb;
    #1;
    chk("busy_start", 64'(bus.busy), 64'(3'b001));
    sb_q.push_back({eh, el});
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy !== 3'b000 && cyc < 20) begin
      if (cyc == inj) begin
        bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h0000DEAD;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      chk("busy_mid", 64'(bus.busy), 64'(bits));
      chk("hi_hold", 64'(bus.hi), 64'(m_hi));
      chk("lo_hold", 64'(bus.lo), 64'(m_lo));
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    chk("busy_cycles", 64'(cyc), 64'(n));
    sb_retire();
  endtask

  // MTHI/MTLO or reserved: no busy, new value visible one cycle later
  task automatic short_op(input logic [2:0] o, input logic [31:0] aa);
    bus.start = 1'b1; bus.op = o; bus.a = aa; bus.b = 32'd0;
    #1;
    chk("busy_short", 64'(bus.busy), 64'(3'b000));
    sb_q.push_back({(o == 3'd4) ? aa : m_hi, (o == 3'd5) ? aa : m_lo});
    tick();
    bus.start = 1'b0;
    chk("busy_after_short", 64'(bus.busy), 64'(3'b000));
    sb_retire();
  endtask

  initial begin
    m_hi = 32'd0;
    m_lo = 32'd0;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    reset = 1'b1;
    tick();
    // Start coinciding with reset must be dropped
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hAAAA5555;
    tick();
    bus.start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      tick();
    end

    long_op(3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, -1);
    long_op(3'd1, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5, -1);
    long_op(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, -1);
    long_op(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10, -1);

    short_op(3'd4, 32'h00001234);
    short_op(3'd5, 32'h00005678);
    short_op(3'd6, 32'hCAFEF00D);
    long_op(3'd2, 32'd99, 32'd0, 32'h00001234, 32'h00005678, 10, -1);

    // Start during a multiply must not disturb it
    long_op(3'd0, 32'd5, 32'd6, 32'd0, 32'd30, 5, 2);

    // Reset on the third busy cycle of a divide aborts it
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("abort_busy", 64'(bus.busy), 64'(3'b100));
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("abort_hi", 64'(bus.hi), 64'd0);
      chk("abort_lo", 64'(bus.lo), 64'd0);
      chk("abort_busy0", 64'(bus.busy), 64'd0);
      tick();
    end

    long_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, -1);
    long_op(3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5, -1);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
